// File: rtl/scs8hd_o21a_capture.sv
// OR-AND (o21a) lane array feeding a 2-entry skid buffer with a toggle counter
// and a scan chain threaded through the HEAD and SKID words.
module scs8hd_o21a_capture #(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
`ifdef SC_USE_PG_PIN
  input  logic             vpwr,
  input  logic             vgnd,
  input  logic             vpb,
  input  logic             vnb,
`endif
  input  logic             CLK,
  input  logic             RESET,
  input  logic [WIDTH-1:0] A1,
  input  logic [WIDTH-1:0] A2,
  input  logic [WIDTH-1:0] B1,
  input  logic             IN_VALID,
  output logic             IN_READY,
  output logic [WIDTH-1:0] X,
  output logic             OUT_VALID,
  input  logic             OUT_READY,
  input  logic             SCE,
  input  logic             SCD,
  output logic             SCQ,
  output logic [CNT_W-1:0] TOG_CNT,
  output logic             TOG_SAT
);

  typedef enum logic [1:0] {EMPTY, ONE, TWO} state_t;

  state_t             state_p1, state_d;
  logic [WIDTH-1:0]   head_p1, head_d;
  logic [WIDTH-1:0]   skid_p1, skid_d;
  logic [WIDTH-1:0]   last_p1;
  logic [CNT_W-1:0]   cnt_p1;
  logic               in_ready_p1;
  logic [WIDTH-1:0]   word_p0;
  logic               accept, pop, vld_p1;

  function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
    return (v == {CNT_W{1'b1}}) ? v : v + CNT_W'(1);
  endfunction

  // ---- stage p0: combinational lane function and handshake qualification
  assign word_p0 = (A1 | A2) & B1;
  assign vld_p1  = (state_p1 != EMPTY);
  assign accept  = IN_VALID & in_ready_p1 & ~SCE & ~RESET;
  assign pop     = vld_p1 & OUT_READY & ~SCE & ~RESET;

  always_comb begin
    state_d = state_p1;
    head_d  = head_p1;
    skid_d  = skid_p1;
    if (SCE) begin
      // Scan shifts the storage chain while the handshake state is frozen.
      head_d = {head_p1[WIDTH-2:0], SCD};
      skid_d = {skid_p1[WIDTH-2:0], head_p1[WIDTH-1]};
    end else begin
      case (state_p1)
        EMPTY: if (accept) begin
          state_d = ONE;
          head_d  = word_p0;
        end
        ONE: begin
          if (accept && pop) begin
            head_d = word_p0;
          end else if (accept) begin
            state_d = TWO;
            skid_d  = word_p0;
          end else if (pop) begin
            state_d = EMPTY;
          end
        end
        TWO: if (pop) begin
          state_d = ONE;
          head_d  = skid_p1;
        end
        default: state_d = EMPTY;
      endcase
    end
  end

  // ---- stage p1: storage, ready flag and toggle statistics
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_p1    <= EMPTY;
      head_p1     <= '0;
      skid_p1     <= '0;
      last_p1     <= '0;
      cnt_p1      <= '0;
      in_ready_p1 <= 1'b1;
    end else begin
      state_p1    <= state_d;
      head_p1     <= head_d;
      skid_p1     <= skid_d;
      in_ready_p1 <= (state_d != TWO);
      if (accept) begin
        last_p1 <= word_p0;
        if (word_p0 != last_p1) cnt_p1 <= sat_inc(cnt_p1);
      end
    end
  end

  assign IN_READY  = in_ready_p1;
  assign X         = head_p1;
  assign OUT_VALID = vld_p1;
  assign SCQ       = skid_p1[WIDTH-1];
  assign TOG_CNT   = cnt_p1;
  assign TOG_SAT   = (cnt_p1 == {CNT_W{1'b1}});

endmodule

// File: tb/tb_scs8hd_o21a_capture.sv
// Scoreboard bench: stimulus queues expected words, a negedge monitor checks pops.
module tb_scs8hd_o21a_capture;

  logic       clk = 1'b0;
  logic       reset, in_valid, out_ready, sce, scd;
  logic [3:0] a1, a2, b1;
  logic       in_ready, out_valid, scq, tog_sat;
  logic [3:0] x;
  logic [7:0] tog_cnt;
  logic       in_ready2, out_valid2, scq2, tog_sat2;
  logic [3:0] x2;
  logic [1:0] tog_cnt2;

  int errors = 0;
  int checks = 0;
  logic [3:0] exp_q[$];

  always #5 clk = ~clk;

  scs8hd_o21a_capture #(.WIDTH(4), .CNT_W(8)) dut (
    .CLK(clk), .RESET(reset), .A1(a1), .A2(a2), .B1(b1),
    .IN_VALID(in_valid), .IN_READY(in_ready), .X(x), .OUT_VALID(out_valid),
    .OUT_READY(out_ready), .SCE(sce), .SCD(scd), .SCQ(scq),
    .TOG_CNT(tog_cnt), .TOG_SAT(tog_sat));

  scs8hd_o21a_capture #(.WIDTH(4), .CNT_W(2)) dut2 (
    .CLK(clk), .RESET(reset), .A1(a1), .A2(a2), .B1(b1),
    .IN_VALID(in_valid), .IN_READY(in_ready2), .X(x2), .OUT_VALID(out_valid2),
    .OUT_READY(out_ready), .SCE(sce), .SCD(scd), .SCQ(scq2),
    .TOG_CNT(tog_cnt2), .TOG_SAT(tog_sat2));

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a pop happens at the next edge whenever these conditions hold.
  always @(negedge clk) begin
    if (out_valid && out_ready && !sce && !reset) begin
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL pop_unexpected: got %0h expected none", x);
      end else begin
        if (x !== exp_q[0]) begin
          errors++;
          $display("FAIL pop_data: got %0h expected %0h", x, exp_q[0]);
        end
        void'(exp_q.pop_front());
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
    exp_q.delete();
  endtask

  task automatic send(input logic [3:0] va1, input logic [3:0] va2,
                      input logic [3:0] vb1, input logic [3:0] exp);
    int n;
    n = 0;
    a1 = va1; a2 = va2; b1 = vb1; in_valid = 1'b1;
    while (1) begin
      @(negedge clk);
      if (in_ready && !sce && !reset) begin
        exp_q.push_back(exp);
        break;
      end
      n++;
      if (n > 50) begin
        chk("send_timeout", 32'd1, 32'd0);
        break;
      end
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  initial begin
    logic [7:0] pat;
    logic [7:0] scq_exp;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0; sce = 1'b0; scd = 1'b0;
    a1 = '0; a2 = '0; b1 = '0;
    tick();
    tick();
    chk("rst_x", x, 4'h0);
    chk("rst_out_valid", out_valid, 1'b0);
    chk("rst_in_ready", in_ready, 1'b1);
    chk("rst_tog_cnt", tog_cnt, 8'd0);
    chk("rst_tog_sat", tog_sat, 1'b0);
    chk("rst_scq", scq, 1'b0);
    reset = 1'b0;

    // Single word through an empty buffer
    out_ready = 1'b1;
    send(4'b0011, 4'b0100, 4'b0110, 4'b0110);
    chk("basic_x", x, 4'b0110);
    chk("basic_out_valid", out_valid, 1'b1);
    chk("basic_tog_cnt", tog_cnt, 8'd1);
    tick();

    // Fill both entries with the consumer stalled
    out_ready = 1'b0;
    send(4'hF, 4'h0, 4'hF, 4'hF);
    send(4'h1, 4'h0, 4'h1, 4'h1);
    chk("two_in_ready", in_ready, 1'b0);
    chk("two_x", x, 4'hF);
    chk("two_out_valid", out_valid, 1'b1);
    chk("two_tog_cnt", tog_cnt, 8'd3);
    out_ready = 1'b1;
    tick();
    chk("drain_x", x, 4'h1);
    chk("drain_in_ready", in_ready, 1'b1);
    tick();
    chk("drain_empty", out_valid, 1'b0);
    chk("drain_q", exp_q.size(), 0);

    // Streaming identical words at full rate
    do_reset();
    out_ready = 1'b1;
    a1 = 4'h5; a2 = 4'h0; b1 = 4'hF; in_valid = 1'b1;
    for (int i = 0; i < 6; i++) begin
      @(negedge clk);
      chk("stream_in_ready", in_ready, 1'b1);
      if (in_ready) exp_q.push_back(4'h5);
      @(posedge clk);
      #1;
      chk("stream_out_valid", out_valid, 1'b1);
    end
    in_valid = 1'b0;
    tick();
    tick();
    chk("stream_tog_cnt", tog_cnt, 8'd1);
    chk("stream_q", exp_q.size(), 0);

    // Alternating words saturate the narrow counter
    do_reset();
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) send(4'h0, 4'h0, 4'hF, 4'h0);
      else            send(4'hF, 4'h0, 4'hF, 4'hF);
    end
    tick();
    chk("sat_cnt2", tog_cnt2, 2'd3);
    chk("sat_flag2", tog_sat2, 1'b1);
    chk("sat_cnt8", tog_cnt, 8'd4);
    chk("sat_flag8", tog_sat, 1'b0);
    chk("sat_q", exp_q.size(), 0);

    // Scan shift while holding two words
    do_reset();
    out_ready = 1'b0;
    send(4'hA, 4'h0, 4'hF, 4'hA);
    send(4'h3, 4'h0, 4'hF, 4'h3);
    pat = 8'hA5;
    scq_exp = 8'b0011_1010;
    sce = 1'b1;
    for (int k = 0; k < 8; k++) begin
      scd = pat[7-k];
      @(negedge clk);
      chk("scan_scq", scq, scq_exp[7-k]);
      @(posedge clk);
      #1;
    end
    chk("scan_in_ready", in_ready, 1'b0);
    chk("scan_out_valid", out_valid, 1'b1);
    sce = 1'b0;
    chk("scan_x", x, 4'h5);
    exp_q.delete();
    exp_q.push_back(4'h5);
    exp_q.push_back(4'hA);
    out_ready = 1'b1;
    tick();
    tick();
    tick();
    chk("scan_drain_q", exp_q.size(), 0);
    chk("scan_drain_empty", out_valid, 1'b0);

    // Reset overrides scan with two words held
    out_ready = 1'b0;
    send(4'h7, 4'h0, 4'hF, 4'h7);
    send(4'h2, 4'h0, 4'hF, 4'h2);
    sce = 1'b1;
    reset = 1'b1;
    tick();
    chk("rst2_out_valid", out_valid, 1'b0);
    chk("rst2_x", x, 4'h0);
    chk("rst2_in_ready", in_ready, 1'b1);
    chk("rst2_tog_cnt", tog_cnt, 8'd0);
    chk("rst2_scq", scq, 1'b0);
    reset = 1'b0;
    sce = 1'b0;
    exp_q.delete();
    tick();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog expired");
  end

endmodule
